// File: rtl/ifetch_align.sv
// Instruction fetch front end: word fetch from a registered imem,
// halfword queue, and RV32C/RV32I realignment toward decode.
module ifetch_align #(
    parameter int          ADDR_WIDTH = 9,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_dout,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [31:0]           redirect_pc,
    output logic                  instr_valid,
    output logic [31:0]           instr,
    output logic [31:0]           instr_pc,
    output logic                  instr_compressed
);

    logic [31:0]      fetch_pc;
    logic [31:0]      head_pc;
    logic             rsp_pending;
    logic             drop_low;
    logic [3:0][15:0] q;
    logic [2:0]       cnt;

    logic             head_c;
    logic [1:0]       cons;
    logic [1:0]       app;
    logic [3:0][15:0] q_c;
    logic [3:0][15:0] q_n;
    logic [2:0]       cnt_c;
    logic [3:0]       cnt_n4;
    logic             req;
    logic [31:0]      head_pc_n;
    logic [31:0]      fetch_next;
    logic [31:0]      redir_next;
    logic             unused;

    assign unused = ^{redirect_pc[0], fetch_pc[1:0]};

    // Address mux: a redirect target is requested in the same cycle.
    assign imem_addr = redirect ? redirect_pc[ADDR_WIDTH+1:2]
                                : fetch_pc[ADDR_WIDTH+1:2];

    // Decode-facing view of the queue head; never depends on imem or stall.
    always_comb begin
        head_c           = (q[0][1:0] != 2'b11);
        instr_valid      = (cnt >= 3'd2) || ((cnt == 3'd1) && head_c);
        instr_compressed = (cnt != 3'd0) && head_c;
        instr            = instr_compressed ? {16'h0000, q[0]}
                                            : {q[1], q[0]};
        instr_pc         = head_pc;
    end

    // Next queue contents: pop the consumed head, then append the response.
    always_comb begin
        cons = 2'd0;
        if (instr_valid && !stall)
            cons = instr_compressed ? 2'd1 : 2'd2;

        case (cons)
            2'd1:    q_c = {16'h0000, q[3:1]};
            2'd2:    q_c = {32'h0000_0000, q[3:2]};
            default: q_c = q;
        endcase
        cnt_c = cnt - {1'b0, cons};

        app = 2'd0;
        if (rsp_pending)
            app = drop_low ? 2'd1 : 2'd2;

        q_n = q_c;
        for (int i = 0; i < 4; i++) begin
            if (rsp_pending) begin
                if (drop_low) begin
                    if (3'(i) == cnt_c)
                        q_n[i] = imem_dout[31:16];
                end else begin
                    if (3'(i) == cnt_c)
                        q_n[i] = imem_dout[15:0];
                    else if (3'(i) == cnt_c + 3'd1)
                        q_n[i] = imem_dout[31:16];
                end
            end
        end

        cnt_n4     = {1'b0, cnt_c} + {2'b00, app};
        req        = !redirect && (cnt_n4 <= 4'd2);
        head_pc_n  = head_pc + {29'b0, cons, 1'b0};
        fetch_next = {fetch_pc[31:2], 2'b00} + 32'd4;
        redir_next = {redirect_pc[31:2], 2'b00} + 32'd4;
    end

    // Queue, PC and request-tracking state; redirect overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q           <= '0;
            cnt         <= 3'd0;
            head_pc     <= RESET_PC;
            fetch_pc    <= RESET_PC;
            rsp_pending <= 1'b0;
            drop_low    <= RESET_PC[1];
        end else if (redirect) begin
            cnt         <= 3'd0;
            head_pc     <= redirect_pc;
            fetch_pc    <= redir_next;
            rsp_pending <= 1'b1;
            drop_low    <= redirect_pc[1];
        end else begin
            q           <= q_n;
            cnt         <= cnt_n4[2:0];
            head_pc     <= head_pc_n;
            rsp_pending <= req;
            if (req) begin
                fetch_pc <= fetch_next;
                drop_low <= 1'b0;
            end
        end
    end

    // Requests are gated so a response always fits in the queue.
    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rst_n)
        redirect || (cnt_n4 <= 4'd4)
    );

endmodule

// File: tb/tb_ifetch_align.sv
// Directed bench for ifetch_align: reset, streams, stall,
// redirect, async reset mid-stream and address wrap.
module tb_ifetch_align;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [8:0]  imem_addr;
    logic [31:0] imem_dout;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_compressed;

    logic [8:0]  imem_addr_w;
    logic [31:0] imem_dout_w;
    logic        instr_valid_w;
    logic [31:0] instr_w;
    logic [31:0] instr_pc_w;
    logic        instr_compressed_w;

    logic [31:0] mem   [512];
    logic [31:0] mem_w [512];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_dout   <= mem[imem_addr];
        imem_dout_w <= mem_w[imem_addr_w];
    end

    ifetch_align #(
        .ADDR_WIDTH(9),
        .DATA_WIDTH(32),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr(imem_addr),
        .imem_dout(imem_dout),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_compressed(instr_compressed)
    );

    ifetch_align #(
        .ADDR_WIDTH(9),
        .DATA_WIDTH(32),
        .RESET_PC(32'h0000_07FC)
    ) dut_w (
        .clk(clk),
        .rst_n(rst_n),
        .imem_addr(imem_addr_w),
        .imem_dout(imem_dout_w),
        .stall(1'b0),
        .redirect(1'b0),
        .redirect_pc(32'h0),
        .instr_valid(instr_valid_w),
        .instr(instr_w),
        .instr_pc(instr_pc_w),
        .instr_compressed(instr_compressed_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        rst_n       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        tick();
    endtask

    task automatic load_distinct();
        for (int i = 0; i < 512; i++)
            mem[i] = 32'h0000_0013 | (32'(i % 2048) << 20);
    endtask

    task automatic test_reset();
        logic [65:0] exp;
        for (int i = 0; i < 512; i++) begin
            mem[i]   = 32'h0000_0013;
            mem_w[i] = 32'h0000_0013;
        end
        start();
        exp = {1'b0, 1'b0, 32'h0, 32'h0};
        checks++;
        if ({instr_valid, instr_compressed, instr_pc, instr} !== exp) begin
            errors++;
            $display("FAIL reset_out: got %h expected %h",
                     {instr_valid, instr_compressed, instr_pc, instr}, exp);
        end
        checks++;
        if (imem_addr !== 9'd0) begin
            errors++;
            $display("FAIL reset_addr: got %0d expected 0", imem_addr);
        end
        checks++;
        if (imem_addr_w !== 9'd511) begin
            errors++;
            $display("FAIL reset_addr_w: got %0d expected 511", imem_addr_w);
        end
        checks++;
        if (instr_pc_w !== 32'h7FC || instr_valid_w !== 1'b0) begin
            errors++;
            $display("FAIL reset_w: got pc %h v %b expected pc 7fc v 0",
                     instr_pc_w, instr_valid_w);
        end
    endtask

    task automatic test_nop_stream();
        logic [65:0] exp;
        rst_n = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 9'd1) begin
            errors++;
            $display("FAIL nop_edge1: got v %b addr %0d expected v 0 addr 1",
                     instr_valid, imem_addr);
        end
        checks++;
        if (instr !== 32'h0 && instr_valid === 1'b1) begin
            errors++;
            $display("FAIL nop_edge1_instr: got %h expected none", instr);
        end
        for (int k = 2; k <= 5; k++) begin
            tick();
            exp = {1'b1, 1'b0, 32'((k - 2) * 4), 32'h0000_0013};
            checks++;
            if ({instr_valid, instr_compressed, instr_pc, instr} !== exp) begin
                errors++;
                $display("FAIL nop_stream[%0d]: got %h expected %h", k,
                         {instr_valid, instr_compressed, instr_pc, instr}, exp);
            end
            checks++;
            if (imem_addr !== 9'(k)) begin
                errors++;
                $display("FAIL nop_addr[%0d]: got %0d expected %0d",
                         k, imem_addr, k);
            end
        end
    endtask

    task automatic test_mixed();
        logic [65:0] exp;
        start();
        mem[0] = 32'h0093_0001;
        mem[1] = 32'h0000_00A0;
        rst_n = 1'b1;
        tick();
        tick();
        exp = {1'b1, 1'b1, 32'h0, 32'h0000_0001};
        checks++;
        if ({instr_valid, instr_compressed, instr_pc, instr} !== exp) begin
            errors++;
            $display("FAIL mixed_c16: got %h expected %h",
                     {instr_valid, instr_compressed, instr_pc, instr}, exp);
        end
        tick();
        exp = {1'b1, 1'b0, 32'h2, 32'h00A0_0093};
        checks++;
        if ({instr_valid, instr_compressed, instr_pc, instr} !== exp) begin
            errors++;
            $display("FAIL mixed_straddle: got %h expected %h",
                     {instr_valid, instr_compressed, instr_pc, instr}, exp);
        end
        tick();
        exp = {1'b1, 1'b1, 32'h6, 32'h0};
        checks++;
        if ({instr_valid, instr_compressed, instr_pc, instr} !== exp) begin
            errors++;
            $display("FAIL mixed_tail: got %h expected %h",
                     {instr_valid, instr_compressed, instr_pc, instr}, exp);
        end
    endtask

    task automatic test_stall();
        logic [65:0] exp;
        start();
        load_distinct();
        rst_n = 1'b1;
        repeat (4) tick();
        exp = {1'b1, 1'b0, 32'h8, 32'h0020_0013};
        checks++;
        if ({instr_valid, instr_compressed, instr_pc, instr} !== exp) begin
            errors++;
            $display("FAIL stall_pre: got %h expected %h",
                     {instr_valid, instr_compressed, instr_pc, instr}, exp);
        end
        stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++;
            if ({instr_valid, instr_compressed, instr_pc, instr} !== exp) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", j,
                         {instr_valid, instr_compressed, instr_pc, instr}, exp);
            end
            checks++;
            if (imem_addr !== 9'd4) begin
                errors++;
                $display("FAIL stall_addr[%0d]: got %0d expected 4",
                         j, imem_addr);
            end
        end
        stall = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            exp = {1'b1, 1'b0, 32'(12 + 4 * j),
                   32'h0000_0013 | (32'(3 + j) << 20)};
            checks++;
            if ({instr_valid, instr_compressed, instr_pc, instr} !== exp) begin
                errors++;
                $display("FAIL stall_resume[%0d]: got %h expected %h", j,
                         {instr_valid, instr_compressed, instr_pc, instr}, exp);
            end
        end
    endtask

    task automatic test_redirect();
        logic [65:0] exp;
        start();
        mem[0] = 32'h0000_0013;
        mem[1] = 32'h0010_0013;
        mem[2] = 32'h0013_0001;
        mem[3] = 32'h0000_0000;
        rst_n = 1'b1;
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_000A;
        stall       = 1'b1;
        #1;
        checks++;
        if (imem_addr !== 9'd2) begin
            errors++;
            $display("FAIL redir_addr: got %0d expected 2", imem_addr);
        end
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush: got valid %b expected 0", instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_half: got valid %b expected 0", instr_valid);
        end
        tick();
        exp = {1'b1, 1'b0, 32'hA, 32'h0000_0013};
        checks++;
        if ({instr_valid, instr_compressed, instr_pc, instr} !== exp) begin
            errors++;
            $display("FAIL redir_target: got %h expected %h",
                     {instr_valid, instr_compressed, instr_pc, instr}, exp);
        end
    endtask

    task automatic test_async_reset();
        logic [65:0] exp;
        start();
        load_distinct();
        rst_n = 1'b1;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_valid: got %b expected 0", instr_valid);
        end
        checks++;
        if (instr_pc !== 32'h0 || imem_addr !== 9'd0) begin
            errors++;
            $display("FAIL arst_pc: got pc %h addr %0d expected 0 0",
                     instr_pc, imem_addr);
        end
        #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL arst_edge1: got valid %b expected 0", instr_valid);
        end
        tick();
        exp = {1'b1, 1'b0, 32'h0, 32'h0000_0013};
        checks++;
        if ({instr_valid, instr_compressed, instr_pc, instr} !== exp) begin
            errors++;
            $display("FAIL arst_restart: got %h expected %h",
                     {instr_valid, instr_compressed, instr_pc, instr}, exp);
        end
        tick();
        exp = {1'b1, 1'b0, 32'h4, 32'h0010_0013};
        checks++;
        if ({instr_valid, instr_compressed, instr_pc, instr} !== exp) begin
            errors++;
            $display("FAIL arst_next: got %h expected %h",
                     {instr_valid, instr_compressed, instr_pc, instr}, exp);
        end
    endtask

    task automatic test_wrap();
        logic [65:0] exp;
        start();
        mem_w[511] = 32'h0010_0013;
        mem_w[0]   = 32'h0020_0013;
        mem_w[1]   = 32'h0030_0013;
        checks++;
        if (imem_addr_w !== 9'd511) begin
            errors++;
            $display("FAIL wrap_rst_addr: got %0d expected 511", imem_addr_w);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (imem_addr_w !== 9'd0) begin
            errors++;
            $display("FAIL wrap_addr: got %0d expected 0", imem_addr_w);
        end
        tick();
        exp = {1'b1, 1'b0, 32'h7FC, 32'h0010_0013};
        checks++;
        if ({instr_valid_w, instr_compressed_w, instr_pc_w, instr_w} !== exp) begin
            errors++;
            $display("FAIL wrap_first: got %h expected %h",
                     {instr_valid_w, instr_compressed_w, instr_pc_w, instr_w},
                     exp);
        end
        tick();
        exp = {1'b1, 1'b0, 32'h800, 32'h0020_0013};
        checks++;
        if ({instr_valid_w, instr_compressed_w, instr_pc_w, instr_w} !== exp) begin
            errors++;
            $display("FAIL wrap_second: got %h expected %h",
                     {instr_valid_w, instr_compressed_w, instr_pc_w, instr_w},
                     exp);
        end
    endtask

    initial begin
        test_reset();
        test_nop_stream();
        test_mixed();
        test_stall();
        test_redirect();
        test_async_reset();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
